// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
//   Shared definitions for the MIPS HI/LO multiply/divide unit:
//   operation encodings, FSM state encodings, datapath width and
//   iteration count.
package mips_muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    // One product/quotient bit is resolved per clock edge.
    localparam int MULDIV_ITERS = MULDIV_WIDTH;

    // Encodings 6 and 7 are reserved and are not enum members.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_signfix.sv
// mips_muldiv_signfix
//   Conditional two's-complement negate. Used on entry to take operand
//   magnitudes and on exit to restore the sign of the product, quotient
//   or remainder.
// Ports:
//   value  - input word
//   neg    - when high, result is -value; otherwise value passes through
//   result - conditionally negated word
module mips_muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (-value) : value;

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide unit owning the MIPS HI/LO registers.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per
//   edge, followed by a single sign-fixup edge that writes HI and LO.
//   MTHI/MTLO write HI/LO in a single edge.
// Ports:
//   CLK   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request strobe (accepted only while idle)
//   op    - operation select (see muldiv_op_t)
//   a, b  - rs / rt operands, sampled on the accepting edge only
//   busy  - high while a multiply/divide is in flight
//   done  - one-cycle pulse after HI/LO are updated
//   hi/lo - HI and LO registers
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      state;
    logic [CW-1:0]      count;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   opnd;
    logic               neg_lo;  // product or quotient must be negated
    logic               neg_hi;  // remainder must be negated
    logic               is_div;

    // Entry decode and operand magnitudes.
    logic             signed_op, div_op, div_zero, sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    assign div_zero  = div_op && (b == '0);
    assign sign_a    = signed_op && a[WIDTH-1];
    assign sign_b    = signed_op && b[WIDTH-1];

    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.value(a), .neg(sign_a), .result(abs_a));
    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.value(b), .neg(sign_b), .result(abs_b));

    // Shift-add step: conditionally add the multiplicand into the high
    // half; the carry out becomes the new MSB after the right shift.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};

    // Restoring step: the partial remainder is always below the divisor,
    // so the shifted remainder fits in WIDTH+1 bits and the borrow bit of
    // the trial subtraction decides the quotient bit.
    logic [WIDTH:0] div_trial;
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

    // Exit sign fixup.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    mips_muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .neg(neg_lo), .result(prod_fix));
    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quot (.value(acc[WIDTH-1:0]), .neg(neg_lo), .result(quot_fix));
    mips_muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_hi), .result(rem_fix));

    assign busy = (state != ST_IDLE);

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the values from before this edge, regardless of order.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                state  <= ST_MUL;
                                count  <= '0;
                                acc    <= {{WIDTH{1'b0}}, abs_b};
                                opnd   <= abs_a;
                                neg_lo <= sign_a ^ sign_b;
                                neg_hi <= 1'b0;
                                is_div <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide-by-zero runs the raw dividend unsigned:
                                // every trial subtraction succeeds, giving an
                                // all-ones quotient and remainder equal to a.
                                state  <= ST_DIV;
                                count  <= '0;
                                acc    <= {{WIDTH{1'b0}}, div_zero ? a : abs_a};
                                opnd   <= abs_b;
                                neg_lo <= !div_zero && (sign_a ^ sign_b);
                                neg_hi <= !div_zero && sign_a;
                                is_div <= 1'b1;
                            end
                            default: ;  // reserved encodings are ignored
                        endcase
                    end
                end
                ST_MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(MULDIV_ITERS - 1)) state <= ST_FIX;
                end
                ST_DIV: begin
                    if (!div_trial[WIDTH])
                        acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else
                        acc <= {acc[2*WIDTH-2:0], 1'b0};
                    count <= count + 1'b1;
                    if (count == CW'(MULDIV_ITERS - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
//   Directed vectors with hand-computed HI/LO results. The stimulus side
//   pushes expectations (values, completion cycle, busy length) into a
//   queue; a monitor pops one entry per done pulse and compares.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .CLK   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        int          busy_len;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int checks = 0;
    int errors = 0;
    int busy_run = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: one expectation is consumed per done pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check("done_busy_exclusive", {63'd0, busy}, 64'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    exp_t  e;
                    string n;
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check({n, "_hi"},      {32'd0, hi},        {32'd0, e.hi});
                    check({n, "_lo"},      {32'd0, lo},        {32'd0, e.lo});
                    check({n, "_latency"}, 64'(cyc),           64'(e.due));
                    check({n, "_busy"},    64'(busy_run),      64'(e.busy_len));
                end
                busy_run = 0;
            end
        end
    end

    // Issue a request and record what the monitor must see.
    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        bit   mt;
        @(negedge clk);
        mt = (o == OP_MTHI) || (o == OP_MTLO);
        e.hi       = ehi;
        e.lo       = elo;
        e.due      = cyc + (mt ? 1 : 34);
        e.busy_len = mt ? 0 : 33;
        exp_q.push_back(e);
        name_q.push_back(name);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;  // operands must not matter after the start edge
    endtask

    // Drive a one-cycle strobe that must not produce a result.
    task automatic pulse_raw(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);

        // Multiply: signed negative product, unsigned and signed all-ones.
        issue("mult_m3x5",  OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1); drain("mult_m3x5");
        issue("multu_ones", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001); drain("multu_ones");
        issue("mult_ones",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001); drain("mult_ones");
        issue("multu_2p16", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000); drain("multu_2p16");

        // Divide: sign rules, signed overflow, divide-by-zero.
        issue("div_m7d2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD); drain("div_m7d2");
        issue("div_7dm2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD); drain("div_7dm2");
        issue("div_m7dm2",  OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003); drain("div_m7dm2");
        issue("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000); drain("div_ovf");
        issue("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF); drain("divu_big");
        issue("div_m7d0",   OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF); drain("div_m7d0");
        issue("divu_100d0", OP_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF); drain("divu_100d0");

        // MTHI leaves LO alone (LO is 0xFFFFFFFF from the previous divide).
        issue("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF); drain("mthi");

        // MTLO while busy must be ignored: 1000/7 = 142 r 6.
        issue("divu_mtlo_ignored", OP_DIVU, 32'd1000, 32'd7, 32'h0000_0006, 32'h0000_008E);
        repeat (2) @(negedge clk);
        pulse_raw(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        drain("divu_mtlo_ignored");

        // Reserved encodings: no state change, no done.
        pulse_raw(3'd6, 32'h1111_1111, 32'h2222_2222);
        pulse_raw(3'd7, 32'h3333_3333, 32'h4444_4444);
        repeat (3) @(negedge clk);
        check("reserved_busy", {63'd0, busy}, 64'd0);
        check("reserved_hi",   {32'd0, hi},   64'h6);
        check("reserved_lo",   {32'd0, lo},   64'h8E);

        // Reset mid-multiply: abandoned, outputs cleared before the next edge.
        pulse_raw(OP_MULT, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        check("mid_op_busy_before_rst", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_hi",   {32'd0, hi},   64'd0);
        check("rst_async_lo",   {32'd0, lo},   64'd0);
        check("rst_async_busy", {63'd0, busy}, 64'd0);
        check("rst_async_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);  // any stray done would be flagged by the monitor
        check("post_rst_idle_hi", {32'd0, hi}, 64'd0);

        issue("mult_after_rst", OP_MULT, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        drain("mult_after_rst");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
